// File: rtl/seg7_pair_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pair_decoder
// Brief    : Stability-qualified decoder of two active-low 7-segment buses
//            back to packed BCD with per-digit blank/error flags, delivered
//            over a valid/ready handshake.
// Options  : SEG7_HEX_DECODE_EN - also accept hex glyphs A,b,C,d,E,F.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pair_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] bcd,
  output logic [1:0] blank,
  output logic [1:0] err
);

  localparam logic [CNT_W-1:0] c_stable = CNT_W'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    ST_TRACK    = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [13:0]      w_in;
  logic [13:0]      r_sample;
  logic [13:0]      r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_emitted;
  logic             r_valid;
  logic [7:0]       r_bcd;
  logic [1:0]       r_blank;
  logic [1:0]       r_err;
  logic             w_stable;
  logic             w_new_pair;
  logic             w_load;
  logic             w_ack;
  logic [5:0]       w_dec0;
  logic [5:0]       w_dec1;

  // Returns {err, blank, nibble} for one active-low gfedcba pattern.
  function automatic logic [5:0] dec7(input logic [6:0] pat);
    logic [5:0] res;
    res = 6'b10_0000;
    case (pat)
      7'b1000000: res = 6'b00_0000;
      7'b1111001: res = 6'b00_0001;
      7'b0100100: res = 6'b00_0010;
      7'b0110000: res = 6'b00_0011;
      7'b0011001: res = 6'b00_0100;
      7'b0010010: res = 6'b00_0101;
      7'b0000010: res = 6'b00_0110;
      7'b1111000: res = 6'b00_0111;
      7'b0000000: res = 6'b00_1000;
      7'b0010000: res = 6'b00_1001;
`ifdef SEG7_HEX_DECODE_EN
      7'b0001000: res = 6'b00_1010;
      7'b0000011: res = 6'b00_1011;
      7'b1000110: res = 6'b00_1100;
      7'b0100001: res = 6'b00_1101;
      7'b0000110: res = 6'b00_1110;
      7'b0001110: res = 6'b00_1111;
`endif
      7'b1111111: res = 6'b01_0000;
      default:    res = 6'b10_0000;
    endcase
    return res;
  endfunction

  assign w_in = {seg1, seg0};

  // The sample register runs through reset so a pair held across reset
  // counts its first post-reset edge as edge 1.
  always_ff @(posedge clk) begin
    r_sample <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_in != r_sample) begin
      r_cnt <= '0;
    end else if (r_cnt != c_stable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_stable   = (r_cnt == c_stable);
  assign w_new_pair = !r_emitted || (r_sample != r_last);
  assign w_dec0     = dec7(r_sample[6:0]);
  assign w_dec1     = dec7(r_sample[13:7]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_TRACK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_TRACK: begin
        if (w_stable && w_new_pair) begin
          w_load      = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (out_ready) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_TRACK;
        end
      end
      default: w_state_nxt = ST_TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_bcd     <= 8'h00;
      r_blank   <= 2'b11;
      r_err     <= 2'b00;
      r_emitted <= 1'b0;
      r_last    <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_bcd     <= {w_dec1[3:0], w_dec0[3:0]};
      r_blank   <= {w_dec1[4], w_dec0[4]};
      r_err     <= {w_dec1[5], w_dec0[5]};
      r_emitted <= 1'b1;
      r_last    <= r_sample;
    end else if (w_ack) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign bcd       = r_bcd;
  assign blank     = r_blank;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_pair_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_pair_decoder
// Brief    : Randomised scoreboard bench for seg7_pair_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_pair_decoder;

  localparam int STABLE = 4;
`ifdef SEG7_HEX_DECODE_EN
  localparam int NSYM = 16;
`else
  localparam int NSYM = 10;
`endif

  typedef struct packed {
    logic [7:0] bcd;
    logic [1:0] blank;
    logic [1:0] err;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg0 = 7'h7f;
  logic [6:0] seg1 = 7'h7f;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] bcd;
  logic [1:0] blank;
  logic [1:0] err;

  int    checks = 0;
  int    errors = 0;
  word_t expq[$];
  word_t last_acc;
  bit    mon_en = 1'b0;

  logic [6:0]  pat_tab [0:15];
  logic [13:0] m_pair;
  logic [13:0] m_last;
  int          m_hold;
  bit          m_busy;
  bit          m_emitted;

  always #5 clk = ~clk;

  seg7_pair_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg0(seg0), .seg1(seg1),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .blank(blank), .err(err)
  );

  initial begin
    pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001;
    pat_tab[2]  = 7'b0100100; pat_tab[3]  = 7'b0110000;
    pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
    pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000;
    pat_tab[8]  = 7'b0000000; pat_tab[9]  = 7'b0010000;
    pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
    pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001;
    pat_tab[14] = 7'b0000110; pat_tab[15] = 7'b0001110;
  end

  // {err, blank, nibble} by table search over the accepted glyphs.
  function automatic logic [5:0] ref_digit(input logic [6:0] p);
    if (p == 7'h7f) return 6'b01_0000;
    for (int i = 0; i < NSYM; i++)
      if (pat_tab[i] == p) return {2'b00, 4'(i)};
    return 6'b10_0000;
  endfunction

  function automatic word_t ref_word(input logic [13:0] pair);
    logic [5:0] d0, d1;
    word_t w;
    d0 = ref_digit(pair[6:0]);
    d1 = ref_digit(pair[13:7]);
    w.bcd   = {d1[3:0], d0[3:0]};
    w.blank = {d1[4], d0[4]};
    w.err   = {d1[5], d0[5]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: how long the current pair has been held, whether a word
  // is outstanding, and which pair was last handed out.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy    = 1'b0;
      m_emitted = 1'b0;
      expq.delete();
      m_pair    = {seg1, seg0};
      m_hold    = 0;
    end else begin
      if (m_busy) begin
        if (out_ready) m_busy = 1'b0;
      end else if (m_hold >= STABLE && (!m_emitted || m_pair != m_last)) begin
        expq.push_back(ref_word(m_pair));
        m_last    = m_pair;
        m_emitted = 1'b1;
        m_busy    = 1'b1;
      end
      if ({seg1, seg0} == m_pair) begin
        if (m_hold < STABLE) m_hold++;
      end else begin
        m_pair = {seg1, seg0};
        m_hold = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(out_valid), 32'(m_busy));
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("spurious_word", 32'(1), 32'(0));
        end else begin
          check("word", 32'({bcd, blank, err}), 32'(expq[0]));
          if (out_ready && rst_n) begin
            last_acc = {bcd, blank, err};
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_bcd",   32'(bcd),       32'h00);
    check("rst_blank", 32'(blank),     32'h3);
    check("rst_err",   32'(err),       32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    seg1 = pat_tab[2]; seg0 = pat_tab[9]; out_ready = 1'b1;
    tick(10);
    check("t2_bcd", 32'(last_acc.bcd), 32'h29);

    seg0 = pat_tab[1]; tick(2);
    seg0 = pat_tab[9]; tick(10);

    out_ready = 1'b0;
    seg1 = pat_tab[7]; seg0 = pat_tab[1]; tick(20);
    check("t4_held", 32'(out_valid), 32'(1));
    seg1 = pat_tab[3]; seg0 = pat_tab[3]; tick(10);
    out_ready = 1'b1; tick(10);
    check("t4_bcd", 32'(last_acc.bcd), 32'h33);

    seg1 = 7'h7f; seg0 = 7'b1111110; tick(10);
    check("t5_err",   32'(last_acc.err),   32'h1);
    check("t5_blank", 32'(last_acc.blank), 32'h2);
    check("t5_bcd",   32'(last_acc.bcd),   32'h00);

    seg0 = 7'b0001000; tick(10);
`ifdef SEG7_HEX_DECODE_EN
    check("t6_nib", 32'(last_acc.bcd[3:0]), 32'hA);
    check("t6_err", 32'(last_acc.err[0]),   32'h0);
`else
    check("t6_err", 32'(last_acc.err[0]),   32'h1);
`endif

    out_ready = 1'b0;
    seg1 = pat_tab[5]; seg0 = pat_tab[5]; tick(8);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1; tick(10);
    check("t7_reemit", 32'(bcd), 32'h55);
    out_ready = 1'b1; tick(3);

    for (int it = 0; it < 400; it++) begin
      int r0, r1, n;
      r0 = $urandom_range(0, 19);
      r1 = $urandom_range(0, 19);
      seg0 = (r0 < 16) ? pat_tab[r0] : ((r0 == 16) ? 7'h7f : 7'($urandom));
      seg1 = (r1 < 16) ? pat_tab[r1] : ((r1 == 16) ? 7'h7f : 7'($urandom));
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        rst_n     = ($urandom_range(0, 150) != 0);
        tick(1);
      end
      rst_n = 1'b1;
    end

    out_ready = 1'b1;
    tick(12);
    check("drain_queue", 32'(expq.size()), 32'(0));
    check("drain_valid", 32'(out_valid),   32'(0));
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
